// File: rtl/servo_pwm_capture.sv
// Servo PWM pulse-width decoder: measures each high pulse, removes OFFSET, divides by 3.
// Optional watchdog (TIMEOUT output) is built only when SERVO_CAP_TIMEOUT_EN is defined.
module servo_pwm_capture #(
   parameter int unsigned OFFSET      = 25_001,
   parameter int unsigned MAX_D       = 98_303,
   parameter int unsigned TIMEOUT_CYC = 1_250_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pwm_in,
   output logic [14:0] valor,
   output logic        valid,
   output logic        range_err,
   output logic        timeout
);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   localparam logic [19:0] OFFSET_W = 20'(OFFSET);
   localparam logic [19:0] MAX_D_W  = 20'(MAX_D);
   localparam logic [19:0] W_MAX    = 20'hFFFFF;

   state_t      state, next_state;
   logic        sync1, s, s_d;
   logic        rise, fall;
   logic [19:0] width;
   logic        armed;
   logic        under, over;
   logic [19:0] diff;
   logic        capture, step, done;
   logic [16:0] quo;
   logic [1:0]  rem;
   logic [4:0]  step_cnt;
   logic        cap_under, cap_over;
   logic [2:0]  trial;
   logic        quo_bit;
   logic [1:0]  rem_next;

   // Flops reset high so a pin already high at reset release gives no rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         s     <= 1'b1;
         s_d   <= 1'b1;
      end else begin
         sync1 <= pwm_in;
         s     <= sync1;
         s_d   <= s;
      end
   end

   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width <= 20'd0;
         armed <= 1'b0;
      end else if (rise) begin
         width <= 20'd1;
         armed <= 1'b1;
      end else if (s && width != W_MAX) begin
         width <= width + 20'd1;
      end
   end

   assign under = width < OFFSET_W;
   assign diff  = width - OFFSET_W;
   assign over  = !under && (diff > MAX_D_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      step       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (fall && armed) begin
               capture    = 1'b1;
               next_state = DIV;
            end
         end
         DIV: begin
            step = 1'b1;
            if (step_cnt == 5'd16) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Restoring divide by 3: shift one dividend bit into the remainder per cycle
   assign trial    = {rem, quo[16]};
   assign quo_bit  = trial >= 3'd3;
   assign rem_next = quo_bit ? 2'(trial - 3'd3) : trial[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo       <= 17'd0;
         rem       <= 2'd0;
         step_cnt  <= 5'd0;
         cap_under <= 1'b0;
         cap_over  <= 1'b0;
         valor     <= 15'd0;
         range_err <= 1'b0;
         valid     <= 1'b0;
      end else begin
         valid <= done;
         if (capture) begin
            quo       <= diff[16:0];
            rem       <= 2'd0;
            step_cnt  <= 5'd0;
            cap_under <= under;
            cap_over  <= over;
         end else if (step) begin
            quo      <= {quo[15:0], quo_bit};
            rem      <= rem_next;
            step_cnt <= step_cnt + 5'd1;
         end
         if (done) begin
            valor     <= cap_under ? 15'd0 : (cap_over ? 15'h7FFF : quo[14:0]);
            range_err <= cap_under | cap_over;
         end
      end
   end

`ifdef SERVO_CAP_TIMEOUT_EN
   localparam logic [20:0] TO_M1 = 21'(TIMEOUT_CYC - 1);
   logic [20:0] wd;

   // Cleared by the same edge that raises VALID so both change together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd      <= 21'd0;
         timeout <= 1'b0;
      end else begin
         if (rise)                wd <= 21'd0;
         else if (wd != 21'h1FFFFF) wd <= wd + 21'd1;
         if (done)             timeout <= 1'b0;
         else if (wd >= TO_M1) timeout <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Self-checking bench for servo_pwm_capture with scaled-down OFFSET/MAX_D/TIMEOUT_CYC.
module tb_servo_pwm_capture;

   localparam int OFFSET = 101;
   localparam int MAX_D  = 1499;
   localparam int TO     = 4000;
`ifdef SERVO_CAP_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pwm_in = 1'b0;
   logic [14:0] valor;
   logic        valid;
   logic        range_err;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   servo_pwm_capture #(
      .OFFSET(OFFSET), .MAX_D(MAX_D), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
      .valor(valor), .valid(valid), .range_err(range_err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Expected code from the measured high time
   function automatic void model(input int n, output int code, output bit err);
      if (n < OFFSET) begin
         code = 0; err = 1'b1;
      end else if (n - OFFSET > MAX_D) begin
         code = 32767; err = 1'b1;
      end else begin
         code = (n - OFFSET) / 3; err = 1'b0;
      end
   endfunction

   // Drops the pin and watches 40 cycles; lat counts edges with the sampling edge as 1
   task automatic measure_fall(output int lat, output int nval, output int v, output bit re);
      pwm_in = 1'b0;
      lat = 0; nval = 0; v = -1; re = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (valid) begin
            nval++;
            if (lat == 0) begin
               lat = k; v = int'(valor); re = range_err;
            end
         end
      end
   endtask

   task automatic send_pulse(input int n, output int lat, output int nval, output int v, output bit re);
      pwm_in = 1'b1;
      repeat (n) @(negedge clk);
      measure_fall(lat, nval, v, re);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (valor !== 15'd0 || valid !== 1'b0 || range_err !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valor=%0d valid=%b err=%b to=%b expected all 0",
                  valor, valid, range_err, timeout);
      end
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (valid !== 1'b0 || valor !== 15'd0) begin
         errors++;
         $display("[TB] FAIL reset_release_low: got valid=%b valor=%0d expected 0/0", valid, valor);
      end
   endtask

   task automatic test_decode();
      int widths[$];
      int lat, nval, v, code;
      bit re, err;
      widths = '{OFFSET, OFFSET - 1, OFFSET + 2, OFFSET + 3, OFFSET + MAX_D,
                 OFFSET + MAX_D + 1, 1, 2000, 1111};
      for (int i = 0; i < 22; i++) widths.push_back(int'($urandom_range(1800, 1)));
      foreach (widths[i]) begin
         send_pulse(widths[i], lat, nval, v, re);
         model(widths[i], code, err);
         checks++;
         if (lat !== 21 || nval !== 1) begin
            errors++;
            $display("[TB] FAIL decode_timing w=%0d: got latency=%0d strobes=%0d expected 21/1",
                     widths[i], lat, nval);
         end
         checks++;
         if (v !== code || re !== err) begin
            errors++;
            $display("[TB] FAIL decode_value w=%0d: got valor=%0d err=%b expected %0d/%b",
                     widths[i], v, re, code, err);
         end
         repeat ($urandom_range(200, 25)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int nval, v, lat, code, hi;
      bit re, err;
      // Second short pulse ends while the first is still being divided
      pwm_in = 1'b1;
      repeat (400) @(negedge clk);
      pwm_in = 1'b0;
      nval = 0; v = -1;
      for (int k = 1; k <= 60; k++) begin
         if (k == 6)  pwm_in = 1'b1;
         if (k == 11) pwm_in = 1'b0;
         @(negedge clk);
         if (valid) begin
            if (nval == 0) v = int'(valor);
            nval++;
         end
      end
      model(400, code, err);
      checks++;
      if (nval !== 1 || v !== code) begin
         errors++;
         $display("[TB] FAIL close_pulses: got strobes=%0d valor=%0d expected 1/%0d", nval, v, code);
      end
      repeat (30) @(negedge clk);

      // Next rise reaches the edge detector in the DONE cycle of the previous pulse
      pwm_in = 1'b1;
      repeat (500) @(negedge clk);
      pwm_in = 1'b0;
      lat = 0; v = -1; hi = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 19) pwm_in = 1'b1;
         @(negedge clk);
         if (pwm_in) hi++;
         if (valid && lat == 0) begin
            lat = k; v = int'(valor);
         end
      end
      model(500, code, err);
      checks++;
      if (lat !== 21 || v !== code) begin
         errors++;
         $display("[TB] FAIL rise_in_done_first: got latency=%0d valor=%0d expected 21/%0d", lat, v, code);
      end
      repeat (700 - hi) @(negedge clk);
      measure_fall(lat, nval, v, re);
      model(700, code, err);
      checks++;
      if (lat !== 21 || nval !== 1 || v !== code || re !== err) begin
         errors++;
         $display("[TB] FAIL rise_in_done_second: got latency=%0d strobes=%0d valor=%0d err=%b expected 21/1/%0d/%b",
                  lat, nval, v, re, code, err);
      end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_reset_high_pin();
      int lat, nval, v;
      bit re;
      rst_n = 1'b0; pwm_in = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      measure_fall(lat, nval, v, re);
      checks++;
      if (nval !== 0) begin
         errors++;
         $display("[TB] FAIL high_at_reset: got strobes=%0d expected 0", nval);
      end
      send_pulse(1101, lat, nval, v, re);
      checks++;
      if (lat !== 21 || v !== 333 || re !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_high_reset: got latency=%0d valor=%0d err=%b expected 21/333/0", lat, v, re);
      end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, nval, v;
      bit re;
      send_pulse(700, lat, nval, v, re);
      repeat (30) @(negedge clk);
      pwm_in = 1'b1;
      repeat (900) @(negedge clk);
      pwm_in = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (valor !== 15'd0 || valid !== 1'b0 || range_err !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got valor=%0d valid=%b err=%b to=%b expected all 0",
                  valor, valid, range_err, timeout);
      end
      rst_n = 1'b1;
      nval = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (valid) nval++;
      end
      checks++;
      if (nval !== 0 || valor !== 15'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset_quiet: got strobes=%0d valor=%0d expected 0/0", nval, valor);
      end
      send_pulse(1000, lat, nval, v, re);
      checks++;
      if (lat !== 21 || nval !== 1 || v !== 299 || re !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_mid_reset: got latency=%0d strobes=%0d valor=%0d err=%b expected 21/1/299/0",
                  lat, nval, v, re);
      end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_timeout();
      int lat, nval, v, cnt;
      bit re;
      pwm_in = 1'b1;
      repeat (300) @(negedge clk);
      measure_fall(lat, nval, v, re);
      cnt = 340;
      checks++;
      if (lat !== 21 || v !== 66) begin
         errors++;
         $display("[TB] FAIL timeout_pulse: got latency=%0d valor=%0d expected 21/66", lat, v);
      end
      while (cnt < TO - 2) begin
         @(negedge clk); cnt++;
      end
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_early: got %b expected 0", timeout);
      end
      while (cnt < TO + 6) begin
         @(negedge clk); cnt++;
      end
      checks++;
      if (timeout !== TO_EN) begin
         errors++;
         $display("[TB] FAIL timeout_set: got %b expected %b", timeout, TO_EN);
      end
      pwm_in = 1'b1;
      repeat (50) @(negedge clk);
      checks++;
      if (timeout !== TO_EN) begin
         errors++;
         $display("[TB] FAIL timeout_hold: got %b expected %b", timeout, TO_EN);
      end
      measure_fall(lat, nval, v, re);
      checks++;
      if (timeout !== 1'b0 || lat !== 21 || v !== 0 || re !== 1'b1) begin
         errors++;
         $display("[TB] FAIL timeout_clear: got to=%b latency=%0d valor=%0d err=%b expected 0/21/0/1",
                  timeout, lat, v, re);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_reset_high_pin();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/servo_pwm_capture.md
# servo_pwm_capture

Decodes a hobby-servo PWM pulse train (50 Hz frame, 0.5–2.5 ms high time, 50 MHz CLK) back into the 15-bit position code consumed by the SERVO generator block. It is the inverse of that block: it measures each high pulse in clock cycles, removes the offset, divides by 3, and presents the code with a one-cycle valid strobe. It is used for loopback self-test of the SERVO output and for reading an external RC receiver into the glove controller.

## Interface
- OFFSET, 25_001: high-time cycle count that maps to code 0. The SERVO block holds PWM high for CONT_PWM+1 cycles.
- TIMEOUT_CYC, 1_250_000: cycles (25 ms) without a rising edge before TIMEOUT asserts.
- CLK  input  1  system clock, 50 MHz, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- PWM_IN  input  1  asynchronous pulse input.
- VALOR  output  15  last decoded code; holds its value between updates.
- VALID  output  1  one-cycle strobe when VALOR updates.
- RANGE_ERR  output  1  level; flags for the last measurement (is the VALOR update clamped?).
- TIMEOUT  output  1  level; signal-loss flag.

## Operation
- Reset values: VALOR=0, VALID=0, RANGE_ERR=0, TIMEOUT=0, FSM=IDLE, ARMED=0, width counter=0.
- Both synchronizer flops and the edge-history flop reset to 1. A PWM_IN that is already high at reset release therefore produces no false rising edge.
- Input path: 2-flop synchronizer gives s. A third flop gives s_d. rise = s & ~s_d; fall = ~s & s_d.
- Width counter W (20 bits):
  - On rise: load 1 and set ARMED.
  - While s=1: increment, saturating at 20'hFFFFF.
  - The counter runs independently of the FSM.
- FSM states: IDLE, DIV, DONE.
  - IDLE to DIV on fall when ARMED=1. Latch W into the capture register.
  - A fall while ARMED=0, or while in DIV/DONE, is ignored and produces no output.
- Range classification, computed on the captured W:
  - W < OFFSET: under-range.
  - D = W − OFFSET > 98_303: over-range.
  - Otherwise in-range. D fits in 17 bits.
- DIV: restoring divide of D[16:0] by 3, one quotient bit per cycle, exactly 17 cycles. The divide runs for every capture, including out-of-range ones, so latency is constant.
- DONE (1 cycle), then return to IDLE:
  - In-range: VALOR = floor(D/3), RANGE_ERR=0.
  - Under-range: VALOR = 0, RANGE_ERR=1.
  - Over-range: VALOR = 32_767, RANGE_ERR=1.
  - VALID=1 for this cycle only.
- Watchdog (see Configuration):
  - A 21-bit counter clears on rise and increments otherwise, saturating.
  - TIMEOUT sets when the counter reaches TIMEOUT_CYC.
  - TIMEOUT clears at the next VALID.
- Reset asserted mid-pulse or mid-divide: all state clears immediately and no VALID is produced. The first pulse after reset is decoded only if its rising edge is seen after reset release.

## Timing
- W equals the number of CLK rising edges at which s was 1 for that pulse. For a clean input this equals the pin high time in cycles.
- Latency: VALID is high exactly 21 cycles after the first CLK edge that samples PWM_IN low.
  - 2 cycles synchronizer.
  - 1 cycle edge and capture.
  - 17 cycles DIV.
  - 1 cycle DONE.
- Pulses closer together than 21 cycles are not decoded.
- Minimum measurable high time is 1 cycle.
- Throughput: one code per pulse. At the 50 Hz frame rate the FSM is idle more than 99% of the time.
- Rise in the same cycle as DONE: the counter restarts normally; the result for the previous pulse is unaffected.
- TIMEOUT asserts TIMEOUT_CYC cycles after the last synchronized rise, ±1 cycle.

## Configuration
- SERVO_CAP_TIMEOUT_EN defined: watchdog counter and TIMEOUT logic are present, as described above.
- SERVO_CAP_TIMEOUT_EN undefined: the watchdog counter is not built and TIMEOUT is tied to 0. All other behaviour and latency are identical.

## Test plan
- Test 1: 50 Hz frames with a high time of 25_001 cycles → VALOR=0, RANGE_ERR=0, VALID 21 cycles after the falling edge.
- Test 2: high times of 62_036 and 123_302 cycles → VALOR=12_345 and VALOR=32_767, RANGE_ERR=0. Repeat as a loopback against SERVO with entrada=12_345 → VALOR=12_345.
- Test 3: high times of 10_000 and 200_000 cycles → VALOR=0 and VALOR=32_767 respectively, RANGE_ERR=1 both times, VALID asserted each time.
- Test 4: PWM_IN high at reset release, then low, then a 50_000-cycle pulse → no VALID for the first falling edge; VALOR=8_333 after the second pulse.
- Test 5: RST_N pulsed low 10 cycles after a falling edge → no VALID, all outputs 0. The next pulse decodes normally.
- Test 6: PWM_IN held low for 1_300_000 cycles after a pulse → with the macro, TIMEOUT=1 at 1_250_000 cycles after the rise and clears at the next VALID. Without the macro, TIMEOUT stays 0.
